hamming_secded_decoder: RTL and testbench
=========================================

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the data bits per codeword.
REQ-002 The block SHALL have parameter PAR_W, default 3, giving the Hamming check bits; legal only when 2^PAR_W >= DATA_W+PAR_W+1.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of each error counter.
REQ-004 The block SHALL use derived widths N = DATA_W+PAR_W and CW_W = N+1.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port in_valid, input, 1 bit: a codeword is offered.
REQ-008 Port in_ready, output, 1 bit: the block accepts the codeword this cycle.
REQ-009 Port in_cw, input, CW_W bits: the received codeword.
REQ-010 Port correct_en, input, 1 bit: 1 = correct single errors, 0 = detect only; sampled with the accepted codeword.
REQ-011 Port clr_cnt, input, 1 bit: synchronous clear of both counters.
REQ-012 Port out_valid, output, 1 bit: a result is held.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 Port out_data, output, DATA_W bits: the decoded data.
REQ-015 Port out_single, output, 1 bit: a single-bit error was detected.
REQ-016 Port out_double, output, 1 bit: an uncorrectable error was detected.
REQ-017 Port out_syndrome, output, PAR_W bits: the computed syndrome.
REQ-018 Port corr_cnt, output, CNT_W bits: the count of single-error results.
REQ-019 Port uncorr_cnt, output, CNT_W bits: the count of double-error results.

Function
REQ-020 The codeword layout SHALL be: in_cw[i-1] holds Hamming position i (1..N); check bits sit at power-of-two positions; data bits fill the remaining positions in ascending order, with data bit 0 at the lowest; in_cw[CW_W-1] is the overall even-parity bit over all other bits.
REQ-021 The syndrome s SHALL be the XOR of the position indices of all set bits at positions 1..N; p SHALL be the XOR of all CW_W bits.
REQ-022 Classification: s=0 and p=0 -> no error; p=1 and s=0 -> single error in the overall-parity bit, data unchanged; p=1 and 1<=s<=N -> single error at position s; p=1 and s>N -> double; s!=0 and p=0 -> double.
REQ-023 For a single error with correct_en=1, position s SHALL be inverted before data extraction; with correct_en=0, data SHALL be extracted raw and out_single still asserted.
REQ-024 For a double error, out_data SHALL be the raw extracted data, out_double=1 and out_single=0.
REQ-025 The pipeline SHALL have two register stages: stage 1 captures in_cw, correct_en, s and p; stage 2 (the output registers) holds the corrected result and flags.
REQ-026 Latency SHALL be 2 cycles from the in_valid&&in_ready edge to out_valid with no backpressure; throughput SHALL be one codeword per cycle.
REQ-027 Stage 2 SHALL load when it is empty or out_ready=1; stage 1 SHALL load when it is empty or stage 2 loads.
REQ-028 in_ready SHALL be the combinational signal !s1_valid || !out_valid || out_ready.
REQ-029 While out_valid=1 and out_ready=0, out_data, out_single, out_double and out_syndrome SHALL hold stable.
REQ-030 Counters SHALL increment only on the output handshake (out_valid&&out_ready): corr_cnt on out_single, uncorr_cnt on out_double.
REQ-031 Counters SHALL saturate at all-ones with no wrap.
REQ-032 clr_cnt=1 SHALL zero both counters and win over a simultaneous increment.
REQ-033 No result SHALL be lost or duplicated under any pattern of in_valid and out_ready.

Reset
REQ-034 rst_n=0 SHALL immediately clear the stage-1 valid bit, out_valid, out_data, out_single, out_double, out_syndrome, corr_cnt and uncorr_cnt to 0, independent of clk.
REQ-035 Codewords in flight at reset SHALL be discarded.
REQ-036 in_ready SHALL be 1 during and after reset.
REQ-037 Operation SHALL resume on the first rising clk edge after rst_n=1.

Verification
REQ-038 Defaults, correct_en=1, input 8'h55 -> 2 cycles later out_data=4'hB, out_single=0, out_double=0, out_syndrome=0.
REQ-039 Input 8'h45 (position 5 flipped) -> out_data=4'hB, out_single=1, out_syndrome=3'd5, corr_cnt=1 after the handshake; with correct_en=0 -> out_data=4'h9, out_single=1.
REQ-040 Input 8'h44 (double error) -> out_data=4'h9, out_double=1, out_syndrome=3'd4, uncorr_cnt=1; input 8'hD5 -> out_data=4'hB, out_single=1, out_syndrome=0.
REQ-041 Stream 5 codewords with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 words are held, all 5 results emerge in order, and held outputs stay stable.
REQ-042 CNT_W=2, 5 single errors with clr_cnt pulsed on the same cycle as the 5th handshake -> corr_cnt reaches 3, holds at 3 through the 4th, then reads 0.
REQ-043 rst_n pulsed low between clk edges with 2 words in flight -> outputs are 0 immediately and nothing emerges after release.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// SECDED Hamming decoder: two-stage valid/ready pipeline with error counters.
// Ports: clk, rst_n, in_valid/in_ready/in_cw/correct_en, clr_cnt,
//        out_valid/out_ready/out_data/out_single/out_double/out_syndrome,
//        corr_cnt, uncorr_cnt.
module hamming_secded_decoder #(
   parameter int DATA_W = 4,
   parameter int PAR_W  = 3,
   parameter int CNT_W  = 8,
   localparam int N     = DATA_W + PAR_W,
   localparam int CW_W  = N + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   input  logic              correct_en,
   input  logic              clr_cnt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_single,
   output logic              out_double,
   output logic [PAR_W-1:0]  out_syndrome,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   logic              s1_valid_q, s1_valid_d;
   logic [N-1:0]      s1_cw_q, s1_cw_d;
   logic              s1_cen_q, s1_cen_d;
   logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
   logic              s1_par_q, s1_par_d;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_single_q, out_single_d;
   logic              out_double_q, out_double_d;
   logic [PAR_W-1:0]  out_syn_q, out_syn_d;

   logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

   logic              s2_load;
   logic              s1_load;
   logic              out_hs;
   logic [PAR_W-1:0]  syn_in;
   logic              par_in;
   logic [PAR_W:0]    syn_ext;
   logic              syn_zero;
   logic              syn_in_range;
   logic              is_single;
   logic              is_double;
   logic [N-1:0]      flip_mask;
   logic [N-1:0]      fix_cw;
   logic [DATA_W-1:0] dec_data;

   assign s2_load  = !out_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;
   assign out_hs   = out_valid_q && out_ready;

   // Syndrome: XOR of the indices of every set bit in positions 1..N.
   always_comb begin
      syn_in = '0;
      for (int i = 1; i <= N; i++) begin
         if (in_cw[i-1]) syn_in = syn_in ^ PAR_W'(i);
      end
      par_in = ^in_cw;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_cw_d    = s1_cw_q;
      s1_cen_d   = s1_cen_q;
      s1_syn_d   = s1_syn_q;
      s1_par_d   = s1_par_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         s1_cw_d    = in_cw[N-1:0];
         s1_cen_d   = correct_en;
         s1_syn_d   = syn_in;
         s1_par_d   = par_in;
      end
   end

   // Syndrome zero with odd parity means the overall-parity bit itself
   // flipped, so it still counts as a single error with nothing to fix.
   always_comb begin
      syn_ext      = {1'b0, s1_syn_q};
      syn_zero     = (s1_syn_q == '0);
      syn_in_range = (syn_ext <= (PAR_W+1)'(N));
      is_single    = s1_par_q && syn_in_range;
      is_double    = (!s1_par_q && !syn_zero) ||
                     (s1_par_q && !syn_in_range);
      flip_mask    = '0;
      if (is_single && s1_cen_q && !syn_zero) begin
         flip_mask = {{(N-1){1'b0}}, 1'b1} << (s1_syn_q - 1'b1);
      end
      fix_cw = s1_cw_q ^ flip_mask;
   end

   // Data bits occupy the non-power-of-two positions in ascending order.
   always_comb begin
      int k;
      k        = 0;
      dec_data = '0;
      for (int i = 1; i <= N; i++) begin
         if ((i & (i - 1)) != 0) begin
            dec_data[k] = fix_cw[i-1];
            k = k + 1;
         end
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_single_d = out_single_q;
      out_double_d = out_double_q;
      out_syn_d    = out_syn_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d   = dec_data;
            out_single_d = is_single;
            out_double_d = is_double;
            out_syn_d    = s1_syn_q;
         end
      end
   end

   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (clr_cnt) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (out_hs) begin
         if (out_single_q && corr_cnt_q != '1)
            corr_cnt_d = corr_cnt_q + CNT_W'(1);
         if (out_double_q && uncorr_cnt_q != '1)
            uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_cw_q      <= '0;
         s1_cen_q     <= 1'b0;
         s1_syn_q     <= '0;
         s1_par_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_single_q <= 1'b0;
         out_double_q <= 1'b0;
         out_syn_q    <= '0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_cw_q      <= s1_cw_d;
         s1_cen_q     <= s1_cen_d;
         s1_syn_q     <= s1_syn_d;
         s1_par_q     <= s1_par_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_single_q <= out_single_d;
         out_double_q <= out_double_d;
         out_syn_q    <= out_syn_d;
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_single   = out_single_q;
   assign out_double   = out_double_q;
   assign out_syndrome = out_syn_q;
   assign corr_cnt     = corr_cnt_q;
   assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: directed vectors, stall, reset,
// saturation and a random error-injection stream against a queue model.
module tb_hamming_secded_decoder;

   typedef struct {
      logic [7:0] cw;
      logic       cen;
      logic [3:0] data;
      logic       sgl;
      logic       dbl;
      logic [2:0] syn;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, correct_en, clr_cnt;
   logic [7:0] in_cw;
   logic       out_valid, out_ready, out_single, out_double;
   logic [3:0] out_data;
   logic [2:0] out_syndrome;
   logic [7:0] corr_cnt, uncorr_cnt;

   logic       b_in_valid, b_in_ready, b_correct_en, b_clr_cnt;
   logic [7:0] b_in_cw;
   logic       b_out_valid, b_out_ready, b_out_single, b_out_double;
   logic [3:0] b_out_data;
   logic [2:0] b_out_syndrome;
   logic [1:0] b_corr_cnt, b_uncorr_cnt;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t pend[$];
   vec_t expq[$];
   int   mdl_corr = 0;
   int   mdl_unc = 0;
   logic hold_pend = 1'b0;
   logic [3:0] held_d;
   logic [4:0] held_f;

   always #5 clk = ~clk;

   hamming_secded_decoder dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
      .correct_en(correct_en), .clr_cnt(clr_cnt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_single(out_single),
      .out_double(out_double), .out_syndrome(out_syndrome),
      .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   hamming_secded_decoder #(.CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cw(b_in_cw),
      .correct_en(b_correct_en), .clr_cnt(b_clr_cnt),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_single(b_out_single),
      .out_double(b_out_double), .out_syndrome(b_out_syndrome),
      .corr_cnt(b_corr_cnt), .uncorr_cnt(b_uncorr_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hamming positions of data bits 0..3 for the 4+3 code.
   function automatic int dpos(input int j);
      int t[4] = '{3, 5, 6, 7};
      return t[j];
   endfunction

   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [7:0] cw;
      cw = '0;
      for (int j = 0; j < 4; j++) cw[dpos(j)-1] = d[j];
      for (int c = 0; c < 3; c++)
         for (int j = 0; j < 4; j++)
            if (((dpos(j) >> c) & 1) == 1)
               cw[(1 << c) - 1] = cw[(1 << c) - 1] ^ d[j];
      cw[7] = ^cw[6:0];
      return cw;
   endfunction

   function automatic logic [3:0] extract(input logic [7:0] cw);
      logic [3:0] d;
      for (int j = 0; j < 4; j++) d[j] = cw[dpos(j)-1];
      return d;
   endfunction

   function automatic logic [2:0] pidx(input int b);
      return (b == 7) ? 3'd0 : 3'(b + 1);
   endfunction

   function automatic vec_t mk(input logic [3:0] d, input int nflip,
                               input logic cen);
      vec_t v;
      int   b0, b1;
      logic [7:0] cw;
      cw = encode(d);
      b0 = $urandom_range(0, 7);
      b1 = (b0 + $urandom_range(1, 7)) % 8;
      v.syn = 3'd0;
      if (nflip >= 1) begin cw[b0] = ~cw[b0]; v.syn = v.syn ^ pidx(b0); end
      if (nflip == 2) begin cw[b1] = ~cw[b1]; v.syn = v.syn ^ pidx(b1); end
      v.cw  = cw;
      v.cen = cen;
      v.sgl = (nflip == 1);
      v.dbl = (nflip == 2);
      v.data = (nflip == 0 || (nflip == 1 && cen)) ? d : extract(cw);
      return v;
   endfunction

   function automatic vec_t mkd(input logic [7:0] cw, input logic cen,
                                input logic [3:0] d, input logic s,
                                input logic db, input logic [2:0] syn);
      vec_t v;
      v.cw = cw; v.cen = cen; v.data = d;
      v.sgl = s; v.dbl = db; v.syn = syn;
      return v;
   endfunction

   task automatic cycle(input logic v, input logic rdy);
      vec_t e;
      @(negedge clk);
      chk("corr_cnt", corr_cnt, mdl_corr);
      chk("uncorr_cnt", uncorr_cnt, mdl_unc);
      if (hold_pend) begin
         chk("hold_data", out_data, held_d);
         chk("hold_flags", {out_single, out_double, out_syndrome}, held_f);
      end
      in_valid = v && (pend.size() > 0);
      if (in_valid) begin
         in_cw      = pend[0].cw;
         correct_en = pend[0].cen;
      end
      out_ready = rdy;
      #1;
      chk("in_ready", in_ready, !(expq.size() == 2 && !rdy));
      if (out_valid && out_ready) begin
         if (expq.size() == 0) begin
            chk("spurious_out", out_valid, 0);
         end else begin
            e = expq.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_single", out_single, e.sgl);
            chk("out_double", out_double, e.dbl);
            chk("out_syndrome", out_syndrome, e.syn);
            if (e.sgl && mdl_corr < 255) mdl_corr++;
            if (e.dbl && mdl_unc < 255) mdl_unc++;
         end
      end
      if (in_valid && in_ready) begin
         expq.push_back(pend.pop_front());
         n_vec++;
      end
      hold_pend = out_valid && !out_ready;
      held_d = out_data;
      held_f = {out_single, out_double, out_syndrome};
   endtask

   task automatic send1();
      cycle(1, 1);
      cycle(0, 1);
      chk("latency_early", out_valid, 0);
      cycle(0, 1);
      chk("latency", expq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int guard;
      rst_n = 0; in_valid = 0; in_cw = 0; correct_en = 1;
      clr_cnt = 0; out_ready = 0;
      b_in_valid = 0; b_in_cw = 0; b_correct_en = 1;
      b_clr_cnt = 0; b_out_ready = 1;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", {out_data, out_single, out_double, out_syndrome}, 0);
      chk("rst_cnt", {corr_cnt, uncorr_cnt}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      pend.push_back(mkd(8'h55, 1, 4'hB, 0, 0, 3'd0)); send1();
      pend.push_back(mkd(8'h45, 1, 4'hB, 1, 0, 3'd5)); send1();
      pend.push_back(mkd(8'h45, 0, 4'h9, 1, 0, 3'd5)); send1();
      pend.push_back(mkd(8'h44, 1, 4'h9, 0, 1, 3'd4)); send1();
      pend.push_back(mkd(8'hD5, 1, 4'hB, 1, 0, 3'd0)); send1();
      cycle(0, 1);
      chk("dir_corr_cnt", corr_cnt, 3);
      chk("dir_uncorr_cnt", uncorr_cnt, 1);

      for (int i = 0; i < 5; i++)
         pend.push_back(mk(4'($urandom), $urandom_range(0, 2), 1'($urandom)));
      cycle(1, 0);
      cycle(1, 0);
      cycle(1, 0);
      chk("stall_in_ready", in_ready, 0);
      cycle(1, 0);
      cycle(1, 0);
      guard = 0;
      while ((pend.size() > 0 || expq.size() > 0) && guard < 30) begin
         cycle(1, 1);
         guard++;
      end
      chk("stall_drain", pend.size() + expq.size(), 0);

      for (int i = 0; i < 400; i++) begin
         if (pend.size() == 0)
            pend.push_back(mk(4'($urandom), $urandom_range(0, 2),
                              1'($urandom)));
         cycle(1'($urandom), ($urandom % 4) != 0);
      end
      pend.delete();
      guard = 0;
      while (expq.size() > 0 && guard < 20) begin
         cycle(0, 1);
         guard++;
      end
      chk("rand_drain", expq.size(), 0);
      cycle(0, 1);

      pend.push_back(mk(4'($urandom), 1, 1));
      pend.push_back(mk(4'($urandom), 2, 1));
      cycle(1, 0);
      cycle(1, 0);
      in_valid = 0;
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out", {out_data, out_single, out_double, out_syndrome}, 0);
      chk("mid_rst_cnt", {corr_cnt, uncorr_cnt}, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      expq.delete();
      pend.delete();
      mdl_corr = 0;
      mdl_unc = 0;
      hold_pend = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (5) cycle(0, 1);
      chk("post_rst_valid", out_valid, 0);

      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         b_in_valid = 1;
         b_in_cw = 8'h45;
         @(negedge clk);
         b_in_valid = 0;
         @(negedge clk);
         chk("b_out_valid", b_out_valid, 1);
         chk("b_out_single", b_out_single, 1);
         b_clr_cnt = (k == 4);
         @(negedge clk);
         b_clr_cnt = 0;
         n_vec++;
         chk("b_corr_cnt", b_corr_cnt, (k == 4) ? 0 : ((k + 1 > 3) ? 3 : k + 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
